// File: rtl/memory16x32_pkg.sv
// Shared constants and the transaction record used by benches driving memory16x32.
package pack;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int MEM_DEPTH  = 16;

    // One cycle of stimulus: reset, access enable, direction, address and write data.
    typedef struct packed {
        logic                  rst;
        logic                  en;
        logic                  wr_en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data_in;
    } mem_txn_t;

endpackage : pack

// File: rtl/memory16x32_if.sv
// Bus bundle for memory16x32.
//
// Access semantics: one access per cycle, no back-pressure. en=1 with wr_en=1
// is a write, en=1 with wr_en=0 is a read. A read sampled at edge N presents
// its word on data_out after edge N, and valid_out is high for exactly that
// cycle. valid_out is low after writes, idle cycles and reset cycles, while
// data_out keeps the last read word (0 after reset).
interface intf
    import pack::*;
#(
    parameter int DATA_WIDTH = pack::DATA_WIDTH,
    parameter int ADDR_WIDTH = pack::ADDR_WIDTH
) (
    input logic clk
);

    logic                  rst;
    logic                  en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    // Memory side.
    modport dut_modport (
        input  clk,
        input  rst,
        input  en,
        input  wr_en,
        input  addr,
        input  data_in,
        output data_out,
        output valid_out
    );

    // Requester side.
    modport tb_modport (
        input  clk,
        output rst,
        output en,
        output wr_en,
        output addr,
        output data_in,
        input  data_out,
        input  valid_out
    );

endinterface : intf

// File: rtl/memory16x32.sv
// 16 x 32 single-port synchronous RAM with registered read data and a read-valid strobe.
module memory16x32
    import pack::*;
#(
    parameter int DATA_WIDTH = pack::DATA_WIDTH,
    parameter int ADDR_WIDTH = pack::ADDR_WIDTH,
    parameter int MEM_DEPTH  = pack::MEM_DEPTH
) (
    intf.dut_modport mem_if
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] data_out_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  valid_out_d;
    logic                  valid_out_q;
    logic                  wr_fire;
    logic                  rd_fire;

    // Decode the access and compute the next output register values.
    always_comb begin
        wr_fire     = mem_if.en &  mem_if.wr_en;
        rd_fire     = mem_if.en & ~mem_if.wr_en;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (rd_fire) begin
            data_out_d  = mem_q[mem_if.addr];
            valid_out_d = 1'b1;
        end
    end

    // Storage array and output registers; reset clears everything and wins over any access.
    always_ff @(posedge mem_if.clk) begin
        if (mem_if.rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                mem_q[mem_if.addr] <= mem_if.data_in;
            end
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign mem_if.data_out  = data_out_q;
    assign mem_if.valid_out = valid_out_q;

endmodule : memory16x32

// File: tb/tb_memory16x32.sv
// Directed and random checks of memory16x32 against a reference array model.
module tb_memory16x32;
    import pack::*;

    logic clk;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [DATA_WIDTH-1:0] model_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] model_dout;
    logic                  model_valid;
    logic [DATA_WIDTH-1:0] exp_q [$];

    intf u_if (.clk(clk));

    memory16x32 dut (.mem_if(u_if));

    // Clock / reset block: 10 ns clock; inputs start with reset asserted.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for every check in the bench.
    task automatic check_val(input string tag, input logic [DATA_WIDTH-1:0] got,
                             input logic [DATA_WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance past the edge, update the model and check outputs.
    task automatic drive_txn(input mem_txn_t t, input string tag);
        u_if.rst     = t.rst;
        u_if.en      = t.en;
        u_if.wr_en   = t.wr_en;
        u_if.addr    = t.addr;
        u_if.data_in = t.data_in;
        @(posedge clk);
        #1;
        if (t.rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
            model_dout  = '0;
            model_valid = 1'b0;
            exp_q.delete();
        end else if (t.en && t.wr_en) begin
            model_mem[t.addr] = t.data_in;
            model_valid       = 1'b0;
        end else if (t.en) begin
            exp_q.push_back(model_mem[t.addr]);
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        check_val({tag, ".valid"}, {{(DATA_WIDTH-1){1'b0}}, u_if.valid_out},
                  {{(DATA_WIDTH-1){1'b0}}, model_valid});
        if (model_valid) begin
            model_dout = exp_q.pop_front();
        end
        check_val({tag, ".data"}, u_if.data_out, model_dout);
    endtask

    task automatic do_reset(input string tag);
        drive_txn('{rst: 1'b1, en: 1'b0, wr_en: 1'b0, addr: '0, data_in: '0}, tag);
    endtask

    task automatic do_write(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d,
                            input string tag);
        drive_txn('{rst: 1'b0, en: 1'b1, wr_en: 1'b1, addr: a, data_in: d}, tag);
    endtask

    task automatic do_read(input logic [ADDR_WIDTH-1:0] a, input string tag);
        drive_txn('{rst: 1'b0, en: 1'b1, wr_en: 1'b0, addr: a, data_in: '0}, tag);
    endtask

    task automatic do_idle(input string tag);
        drive_txn('{rst: 1'b0, en: 1'b0, wr_en: 1'b0, addr: '0, data_in: '0}, tag);
    endtask

    initial begin
        mem_txn_t t;
        logic [DATA_WIDTH-1:0] c;
        n_checks    = 0;
        n_errors    = 0;
        model_dout  = '0;
        model_valid = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
        u_if.rst     = 1'b1;
        u_if.en      = 1'b0;
        u_if.wr_en   = 1'b0;
        u_if.addr    = '0;
        u_if.data_in = '0;

        // Reset for two cycles, then every word reads back as zero.
        do_reset("rst0");
        do_reset("rst1");
        for (int i = 0; i < MEM_DEPTH; i++) begin
            do_read(ADDR_WIDTH'(i), "rst_read");
            check_val("rst_read.const", u_if.data_out, 32'h0000_0000);
        end

        // Write then read the same address on the following cycle.
        do_write(4'd3, 32'hDEAD_BEEF, "wr3");
        check_val("wr3.hold", u_if.data_out, 32'h0000_0000);
        do_read(4'd3, "rd3");
        check_val("rd3.const", u_if.data_out, 32'hDEAD_BEEF);

        // Fill all words, then read back from the top address down.
        for (int i = 0; i < MEM_DEPTH; i++) begin
            do_write(ADDR_WIDTH'(i), 32'h1000_0000 + DATA_WIDTH'(i), "fill");
        end
        for (int i = MEM_DEPTH - 1; i >= 0; i--) begin
            do_read(ADDR_WIDTH'(i), "readback");
            c = 32'h1000_0000 + DATA_WIDTH'(i);
            check_val("readback.const", u_if.data_out, c);
        end
        check_val("last_addr0", u_if.data_out, 32'h1000_0000);

        // Idle hold after a read of 0xDEADBEEF.
        do_write(4'd3, 32'hDEAD_BEEF, "wr3b");
        do_read(4'd3, "rd3b");
        for (int k = 0; k < 3; k++) begin
            do_idle("idle");
            check_val("idle.const", u_if.data_out, 32'hDEAD_BEEF);
            check_val("idle.valid0", {31'b0, u_if.valid_out}, 32'h0);
        end

        // Write coinciding with reset is dropped; read coinciding with reset gives no valid.
        do_write(4'd7, 32'h1234_5678, "wr7");
        drive_txn('{rst: 1'b1, en: 1'b1, wr_en: 1'b1, addr: 4'd7, data_in: 32'hA5A5_A5A5},
                  "rst_wr7");
        do_read(4'd7, "rd7");
        check_val("rd7.const", u_if.data_out, 32'h0000_0000);
        drive_txn('{rst: 1'b1, en: 1'b1, wr_en: 1'b0, addr: 4'd7, data_in: '0}, "rst_rd7");
        check_val("rst_rd7.valid0", {31'b0, u_if.valid_out}, 32'h0);

        // Back-to-back reads of distinct words.
        do_write(4'd0, 32'h0000_00AA, "w0");
        do_write(4'd15, 32'hFFFF_0055, "w15");
        do_read(4'd15, "b2b15");
        check_val("b2b15.const", u_if.data_out, 32'hFFFF_0055);
        do_read(4'd0, "b2b0");
        check_val("b2b0.const", u_if.data_out, 32'h0000_00AA);

        // Random traffic against the reference array.
        for (int k = 0; k < 1000; k++) begin
            t.rst     = ($urandom_range(0, 99) == 0);
            t.en      = ($urandom_range(0, 3) != 0);
            t.wr_en   = $urandom_range(0, 1) == 1;
            t.addr    = ADDR_WIDTH'($urandom_range(0, MEM_DEPTH - 1));
            t.data_in = $urandom();
            drive_txn(t, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_memory16x32
